hms_load_seq: RTL and testbench
===============================

Name: hms_load_seq

Overview:
- Sequencer and arbiter that owns the control inputs of the hours/minutes/seconds clock (ss, sel, load, addr, din, inc, dec).
- Two requesters (port 0 = host register interface, port 1 = front-panel set logic) each submit a full H:M:S time.
- The block picks one requester round-robin and range-checks the time.
- If the time is valid, it drives the clock through pause, load-hours, load-minutes, load-seconds and resume, then acknowledges the requester.

Parameters:
- HRS_MAX, 23, highest legal hours value.
- MS_MAX, 59, highest legal minutes/seconds value.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- req0  input  1  port 0 request; held high until ack0 or err0 is seen
- h0  input  5  port 0 hours
- m0  input  6  port 0 minutes
- s0  input  6  port 0 seconds
- req1, h1, m1, s1  input  1/5/6/6  port 1, same meaning as port 0
- ack0, ack1  output  1  one-cycle pulse: load completed for that port
- err0, err1  output  1  one-cycle pulse: request rejected (out-of-range field)
- busy  output  1  high in every state except IDLE
- ss  output  1  clock start/stop strobe
- sel  output  1  clock field select; constant 0
- inc, dec  output  1  clock adjust; constant 0
- load  output  1  clock load strobe
- addr  output  2  clock load field: 3 = hours, 2 = minutes, 1 = seconds
- din  output  6  clock load data

Behaviour:
- Interface: one clock domain, clk; synchronous active-high reset, rst.
- States: IDLE, STOP, LD_H, LD_M, LD_S, START, ACK, ERR.
- All outputs are decoded only from registered state and the captured data/grant registers. There is no combinational path from any input to any output.
- Reset (synchronous, also mid-sequence): state=IDLE, last_grant=1. All outputs 0: ack*, err*, busy, ss, load, addr=0, din=0.
- rst of this block and of the clock come from the same reset source. Resetting one without the other is unsupported, because a clock left paused would be restarted by the next STOP strobe.
- IDLE, with any req high: grant one port.
  - Only one port requesting: that port wins.
  - Both requesting: the port not equal to last_grant wins, then last_grant is updated.
  - Capture that port's h/m/s into cap_h/cap_m/cap_s.
  - Next state is STOP if cap_h<=HRS_MAX, cap_m<=MS_MAX and cap_s<=MS_MAX; otherwise ERR.
  - The ungranted req is ignored and stays pending.
- STOP: ss=1 for one cycle (pauses the clock into its preload state).
- LD_H: load=1, addr=3, din={1'b0,cap_h}.
- LD_M: load=1, addr=2, din=cap_m.
- LD_S: load=1, addr=1, din=cap_s.
- START: ss=1 for one cycle. The clock counts on this edge, so after it the clock reads cap time +1 s, with normal 59/23 rollover.
- ACK: ack pulse on the granted port, then IDLE.
- ERR: err pulse on the granted port, then IDLE. No ss/load is issued and the clock keeps running.
- Latency: request sampled in IDLE cycle 0 gives STOP in 1, LD_H 2, LD_M 3, LD_S 4, START 5, ACK 6, IDLE 7. A rejected request gives ERR in cycle 1 and IDLE in 2.
- Requester rule: deassert req in the cycle after seeing ack/err. A req high in IDLE is always treated as a new request.
- Inputs h/m/s are sampled only at grant; changes during the sequence are ignored.
- Every error check is inclusive at the max value (23/59 legal, 24/60 illegal). 6-bit values 60–63 and 5-bit values 24–31 are errors.

Decomposition:
- Package hms_ctrl_pkg holds:
  - the state enum;
  - ADDR_SEC=1, ADDR_MIN=2, ADDR_HRS=3;
  - the HRS_MAX/MS_MAX defaults.
- One sub-module, rr_arb2: 2-way round-robin grant with last_grant register, inputs req[1:0] and advance, output gnt[1:0].

Test Plan:
- req0, h0=12, m0=34, s0=56 from reset → ss@1; load addr 3/2/1 with din 12/34/56 @2/3/4; ss@5; ack0@6. The clock reads 12:34:57 after the START edge.
- req0 and req1 together after reset, both valid → port 0 served first (ack0). req1 still high is then granted at the next IDLE → ack1 seven cycles later.
- req1, h1=24, m1=0, s1=0 → err1 in cycle 1; no ss/load; busy high for exactly 1 cycle.
- req0, 23:59:59 → din 23/59/59 loaded; after START the clock reads 00:00:00.
- rst asserted in LD_M → next cycle IDLE, all outputs 0. The clock (reset together) is at 00:00:00 running; a new req0 completes normally.
- Edge check: m0=59 accepted, s0=60 rejected (err0); h0 and m0 changed mid-sequence → captured values are still loaded.

Source files
------------

// File: rtl/hms_ctrl_pkg.sv
// Shared definitions for the H:M:S clock load sequencer.
// Holds the sequencer state encoding, the clock load-field addresses,
// the default legal maxima and a helper that range-checks a full time.
package hms_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_STOP,
      ST_LD_H,
      ST_LD_M,
      ST_LD_S,
      ST_START,
      ST_ACK,
      ST_ERR
   } state_t;

   localparam logic [1:0] ADDR_SEC = 2'd1;
   localparam logic [1:0] ADDR_MIN = 2'd2;
   localparam logic [1:0] ADDR_HRS = 2'd3;

   localparam int unsigned HRS_MAX_DEF = 23;
   localparam int unsigned MS_MAX_DEF  = 59;

   // True when every field is within its inclusive maximum.
   function automatic logic time_ok(input logic [4:0]  h,
                                    input logic [5:0]  m,
                                    input logic [5:0]  s,
                                    input int unsigned hrs_max,
                                    input int unsigned ms_max);
      return (32'(h) <= hrs_max) && (32'(m) <= ms_max) && (32'(s) <= ms_max);
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   req[1:0]  : request per port
//   advance   : a grant is being taken this cycle; update last_grant
//   gnt[1:0]  : one-hot grant (combinational from req and last_grant)
// With both ports requesting, the port that was not granted last wins.
// last_grant resets to 1 so port 0 wins the first tie.
module rr_arb2
   import hms_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);

   logic last_grant;

   always_comb begin
      gnt = '0;
      unique case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
         default: gnt = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= 1'b1;
      end else if (advance && (|req)) begin
         last_grant <= gnt[1];
      end
   end

endmodule

// File: rtl/hms_load_seq.sv
// Load sequencer / arbiter driving the control inputs of the H:M:S clock.
// Two requesters each submit a full time; one is granted round-robin, the
// time is range-checked, and a valid time is written into the clock via
// pause (ss), load hours/minutes/seconds, resume (ss), then acknowledged.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   req0/h0/m0/s0      : port 0 (host) request and time
//   req1/h1/m1/s1      : port 1 (front panel) request and time
//   ack0/ack1          : one-cycle pulse, load completed for that port
//   err0/err1          : one-cycle pulse, request rejected (out of range)
//   busy               : high whenever not IDLE
//   ss, sel, inc, dec  : clock controls (sel/inc/dec tied low)
//   load, addr, din    : clock field load strobe, field select, data
// All outputs decode from registered state/captured data only.
module hms_load_seq
   import hms_ctrl_pkg::*;
#(
   parameter int unsigned HRS_MAX = HRS_MAX_DEF,
   parameter int unsigned MS_MAX  = MS_MAX_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0,
   input  logic [4:0] h0,
   input  logic [5:0] m0,
   input  logic [5:0] s0,
   input  logic       req1,
   input  logic [4:0] h1,
   input  logic [5:0] m1,
   input  logic [5:0] s1,
   output logic       ack0,
   output logic       ack1,
   output logic       err0,
   output logic       err1,
   output logic       busy,
   output logic       ss,
   output logic       sel,
   output logic       inc,
   output logic       dec,
   output logic       load,
   output logic [1:0] addr,
   output logic [5:0] din
);

   state_t     state, state_nx;
   logic [4:0] cap_h;
   logic [5:0] cap_m, cap_s;
   logic       gport;

   logic [1:0] gnt;
   logic       grant_now;
   logic [4:0] sel_h;
   logic [5:0] sel_m, sel_s;

   assign grant_now = (state == ST_IDLE) && (req0 || req1);

   rr_arb2 u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     ({req1, req0}),
      .advance (grant_now),
      .gnt     (gnt)
   );

   // Fields of the winning port; only meaningful while grant_now is high.
   always_comb begin
      sel_h = gnt[1] ? h1 : h0;
      sel_m = gnt[1] ? m1 : m0;
      sel_s = gnt[1] ? s1 : s0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         cap_h <= '0;
         cap_m <= '0;
         cap_s <= '0;
         gport <= 1'b0;
      end else begin
         state <= state_nx;
         if (grant_now) begin
            cap_h <= sel_h;
            cap_m <= sel_m;
            cap_s <= sel_s;
            gport <= gnt[1];
         end
      end
   end

   always_comb begin
      state_nx = state;
      ack0     = 1'b0;
      ack1     = 1'b0;
      err0     = 1'b0;
      err1     = 1'b0;
      busy     = 1'b1;
      ss       = 1'b0;
      sel      = 1'b0;
      inc      = 1'b0;
      dec      = 1'b0;
      load     = 1'b0;
      addr     = '0;
      din      = '0;
      unique case (state)
         ST_IDLE: begin
            busy = 1'b0;
            if (grant_now) begin
               state_nx = time_ok(sel_h, sel_m, sel_s, HRS_MAX, MS_MAX)
                          ? ST_STOP : ST_ERR;
            end
         end
         ST_STOP: begin
            ss       = 1'b1;
            state_nx = ST_LD_H;
         end
         ST_LD_H: begin
            load     = 1'b1;
            addr     = ADDR_HRS;
            din      = {1'b0, cap_h};
            state_nx = ST_LD_M;
         end
         ST_LD_M: begin
            load     = 1'b1;
            addr     = ADDR_MIN;
            din      = cap_m;
            state_nx = ST_LD_S;
         end
         ST_LD_S: begin
            load     = 1'b1;
            addr     = ADDR_SEC;
            din      = cap_s;
            state_nx = ST_START;
         end
         ST_START: begin
            ss       = 1'b1;
            state_nx = ST_ACK;
         end
         ST_ACK: begin
            ack0     = ~gport;
            ack1     = gport;
            state_nx = ST_IDLE;
         end
         ST_ERR: begin
            err0     = ~gport;
            err1     = gport;
            state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_hms_load_seq.sv
// Directed bench for hms_load_seq with a small behavioural model of the
// H:M:S clock it controls, used to check the time after the resume strobe.
module tb_hms_load_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0, req1;
   logic [4:0] h0, h1;
   logic [5:0] m0, m1, s0, s1;
   logic       ack0, ack1, err0, err1, busy, ss, sel, inc, dec, load;
   logic [1:0] addr;
   logic [5:0] din;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   hms_load_seq #(.HRS_MAX(23), .MS_MAX(59)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .h0(h0), .m0(m0), .s0(s0),
      .req1(req1), .h1(h1), .m1(m1), .s1(s1),
      .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
      .busy(busy), .ss(ss), .sel(sel), .inc(inc), .dec(dec),
      .load(load), .addr(addr), .din(din)
   );

   // Behavioural model of the controlled clock.
   logic [4:0] ck_h;
   logic [5:0] ck_m, ck_s;
   logic       ck_run;

   function automatic logic [16:0] tick(input logic [4:0] h, input logic [5:0] m,
                                        input logic [5:0] s);
      logic [4:0] nh;
      logic [5:0] nm, ns;
      nh = h; nm = m; ns = s;
      if (s == 6'd59) begin
         ns = 6'd0;
         if (m == 6'd59) begin
            nm = 6'd0;
            nh = (h == 5'd23) ? 5'd0 : h + 5'd1;
         end else begin
            nm = m + 6'd1;
         end
      end else begin
         ns = s + 6'd1;
      end
      return {nh, nm, ns};
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         ck_h <= '0; ck_m <= '0; ck_s <= '0; ck_run <= 1'b1;
      end else if (ss) begin
         if (ck_run) begin
            ck_run <= 1'b0;
         end else begin
            ck_run <= 1'b1;
            {ck_h, ck_m, ck_s} <= tick(ck_h, ck_m, ck_s);
         end
      end else if (load && !ck_run) begin
         case (addr)
            2'd3: ck_h <= din[4:0];
            2'd2: ck_m <= din;
            2'd1: ck_s <= din;
            default: ;
         endcase
      end else if (ck_run) begin
         {ck_h, ck_m, ck_s} <= tick(ck_h, ck_m, ck_s);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [17:0] obs_vec();
      return {busy, ss, load, addr, din, ack0, ack1, err0, err1, sel, inc, dec};
   endfunction

   // Expected {busy,ss,load,addr,din,ack0,ack1,err0,err1,sel,inc,dec} k cycles after grant.
   function automatic logic [17:0] exp_vec(input int k, input bit port, input logic [4:0] h,
                                           input logic [5:0] m, input logic [5:0] s,
                                           input bit ok);
      logic       b, sv, ld, a0, a1, e0, e1;
      logic [1:0] ad;
      logic [5:0] dd;
      b = 0; sv = 0; ld = 0; ad = 0; dd = 0; a0 = 0; a1 = 0; e0 = 0; e1 = 0;
      if (ok) begin
         case (k)
            1: begin b = 1; sv = 1; end
            2: begin b = 1; ld = 1; ad = 2'd3; dd = {1'b0, h}; end
            3: begin b = 1; ld = 1; ad = 2'd2; dd = m; end
            4: begin b = 1; ld = 1; ad = 2'd1; dd = s; end
            5: begin b = 1; sv = 1; end
            6: begin b = 1; a0 = !port; a1 = port; end
            default: ;
         endcase
      end else if (k == 1) begin
         b = 1; e0 = !port; e1 = port;
      end
      return {b, sv, ld, ad, dd, a0, a1, e0, e1, 3'b000};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_port(input bit port, input logic [4:0] h, input logic [5:0] m,
                           input logic [5:0] s);
      if (port) begin h1 = h; m1 = m; s1 = s; req1 = 1'b1; end
      else      begin h0 = h; m0 = m; s0 = s; req0 = 1'b1; end
   endtask

   // DUT is in IDLE with this port's request already driven.
   task automatic run_seq(input string tag, input bit port, input logic [4:0] h,
                          input logic [5:0] m, input logic [5:0] s, input bit ok,
                          input bit scramble);
      int kmax;
      kmax = ok ? 7 : 2;
      for (int k = 1; k <= kmax; k++) begin
         step();
         chk($sformatf("%s_c%0d", tag, k), 32'(obs_vec()), 32'(exp_vec(k, port, h, m, s, ok)));
         if (scramble && k == 1) begin
            if (port) begin h1 = h1 ^ 5'h0A; m1 = m1 ^ 6'h15; end
            else      begin h0 = h0 ^ 5'h0A; m0 = m0 ^ 6'h15; end
         end
         if (ok && k == 6)
            chk($sformatf("%s_time", tag), 32'({ck_run, ck_h, ck_m, ck_s}),
                32'({1'b1, tick(h, m, s)}));
         if (!ok && k == 1)
            chk($sformatf("%s_run", tag), 32'(ck_run), 32'd1);
         if ((ok && k == 6) || (!ok && k == 1)) begin
            if (port) req1 = 1'b0;
            else      req0 = 1'b0;
         end
      end
   endtask

   initial begin
      rst = 1'b1; req0 = 0; req1 = 0;
      h0 = 0; m0 = 0; s0 = 0; h1 = 0; m1 = 0; s1 = 0;
      step(); step();
      chk("reset_out", 32'(obs_vec()), 32'd0);
      rst = 1'b0;
      step();

      // Basic load on port 0.
      set_port(0, 5'd12, 6'd34, 6'd56);
      run_seq("p0_basic", 0, 5'd12, 6'd34, 6'd56, 1, 0);

      // Simultaneous requests straight after reset: port 0 then port 1.
      rst = 1'b1; step(); rst = 1'b0; step();
      set_port(0, 5'd1, 6'd2, 6'd3);
      set_port(1, 5'd4, 6'd5, 6'd6);
      run_seq("both_p0", 0, 5'd1, 6'd2, 6'd3, 1, 0);
      run_seq("both_p1", 1, 5'd4, 6'd5, 6'd6, 1, 0);

      // Hours out of range on port 1.
      set_port(1, 5'd24, 6'd0, 6'd0);
      run_seq("p1_h24", 1, 5'd24, 6'd0, 6'd0, 0, 0);

      // Maximum legal time rolls over to midnight on resume.
      set_port(0, 5'd23, 6'd59, 6'd59);
      run_seq("p0_max", 0, 5'd23, 6'd59, 6'd59, 1, 0);

      // Reset in LD_M.
      set_port(0, 5'd5, 6'd6, 6'd7);
      for (int k = 1; k <= 3; k++) begin
         step();
         chk($sformatf("pre_rst_c%0d", k), 32'(obs_vec()),
             32'(exp_vec(k, 0, 5'd5, 6'd6, 6'd7, 1)));
      end
      rst = 1'b1; req0 = 1'b0;
      step();
      chk("mid_rst_out", 32'(obs_vec()), 32'd0);
      chk("mid_rst_clk", 32'({ck_run, ck_h, ck_m, ck_s}), 32'({1'b1, 17'd0}));
      rst = 1'b0;
      step();
      set_port(0, 5'd8, 6'd9, 6'd10);
      run_seq("post_rst", 0, 5'd8, 6'd9, 6'd10, 1, 0);

      // Boundaries: minutes 59 accepted with inputs changed mid-sequence; seconds 60 rejected.
      set_port(0, 5'd10, 6'd59, 6'd0);
      run_seq("m59_scr", 0, 5'd10, 6'd59, 6'd0, 1, 1);
      set_port(0, 5'd10, 6'd0, 6'd60);
      run_seq("s60", 0, 5'd10, 6'd0, 6'd60, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, tests=%0d", n_tests);
      $fatal(1);
   end

endmodule
